// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared state encoding and default timing for the DAC SPI writers
package dac_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, LOAD} state_t;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_LDAC_CYCLES = 2;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/dac_spi_writer_if.sv
// dac_spi_writer_if: valid/ready word stream feeding one DAC channel
interface dac_spi_writer_if import dac_spi_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_bits;
    modport master (output in_valid, in_bits, input in_ready);
    modport slave  (input in_valid, in_bits, output in_ready);
endinterface

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: SCK half-period timer producing rise/fall strobes while enabled
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ph_q, ph_d;
    logic          last;
    assign last = cnt_q == CW'(CLK_DIV - 1);
    assign rise = en && last && !ph_q;
    assign fall = en && last && ph_q;
    // count one half period, flip phase at its end; parks at a fresh low phase when disabled
    always_comb begin
        cnt_d = (!en || last) ? '0 : cnt_q + 1'b1;
        ph_d  = !en ? 1'b0 : (last ? !ph_q : ph_q);
    end
    // timer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end
endmodule

// File: rtl/dac_spi_writer.sv
// dac_spi_writer: shifts each accepted word MSB-first to a serial DAC, then pulses LDAC
module dac_spi_writer import dac_spi_pkg::*; #(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int LDAC_CYCLES = DEF_LDAC_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    dac_spi_writer_if.slave    s,
    output logic               busy,
    output logic               done,
    output logic               SCK,
    output logic               CS,
    output logic               SDI,
    output logic               LDAC
);
    localparam int PW = $clog2(max3(CLK_DIV, HOLD_CYCLES, LDAC_CYCLES) + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [PW-1:0]         cnt_q, cnt_d;
    logic                  ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic                  sck_q, sck_d, cs_q, cs_d, sdi_q, sdi_d, ldac_q, ldac_d;
    logic                  rise, fall;
    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .en    (state_q == SHIFT),
        .rise  (rise),
        .fall  (fall)
    );
    assign s.in_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign SCK        = sck_q;
    assign CS         = cs_q;
    assign SDI        = sdi_q;
    assign LDAC       = ldac_q;
    // next frame state; shift_q holds the bits still to send, current bit lives in sdi_q
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        sdi_d   = sdi_q;
        ldac_d  = ldac_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (s.in_valid && ready_q) begin
                state_d = SHIFT;
                shift_d = {s.in_bits[DATA_WIDTH-2:0], 1'b0};
                sdi_d   = s.in_bits[DATA_WIDTH-1];
                bit_d   = '0;
                cs_d    = 1'b0;
            end
            SHIFT: if (rise) begin
                sck_d = 1'b1;
            end else if (fall) begin
                sck_d = 1'b0;
                if (bit_q == BW'(DATA_WIDTH - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    sdi_d   = shift_q[DATA_WIDTH-1];
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            HOLD: if (cnt_q == PW'(HOLD_CYCLES - 1)) begin
                state_d = LOAD;
                cnt_d   = '0;
                cs_d    = 1'b1;
                sdi_d   = 1'b0;
                ldac_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            LOAD: if (cnt_q == PW'(LDAC_CYCLES - 1)) begin
                state_d = IDLE;
                ldac_d  = 1'b1;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
    end
    // frame FSM and registered pin drivers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            sdi_q   <= 1'b0;
            ldac_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            sdi_q   <= sdi_d;
            ldac_q  <= ldac_d;
        end
    end
endmodule
